// File: rtl/spi_buf_sched.sv
// Round-robin scheduler: finds pending command slots on buffer port B, runs them on the SPI engine, writes results back.
// Optional WAIT watchdog is compiled in with `define SPI_SCHED_TIMEOUT_EN.
module spi_buf_sched #(
  parameter int DEPTH_LOG2  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  output logic [DEPTH_LOG2-1:0] buf_addrb,
  input  logic [31:0]           buf_rdata,
  output logic [31:0]           buf_wdata,
  output logic                  web,
  output logic                  eng_start,
  output logic                  eng_rw,
  output logic [6:0]            eng_addr,
  output logic [7:0]            eng_wdata,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [7:0]            eng_rdata,
  output logic                  irq,
  output logic [15:0]           done_cnt,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_EVAL  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic                  r_rw;
  logic [6:0]            r_maddr;
  logic [7:0]            r_mdata;
  logic [31:0]           r_wdata;
  logic [15:0]           r_done_cnt;
  logic                  w_start;
  logic                  w_pending;
  logic                  w_timeout;
  logic                  w_finish;
  logic [7:0]            w_data;
  logic                  w_unused_bits;

  assign w_pending     = buf_rdata[30] & ~buf_rdata[31];
  assign w_unused_bits = &{1'b0, buf_rdata[28:15]};

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] r_to_cnt;

  // Counter is cleared in ISSUE, so each WAIT visit starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !eng_done && (r_to_cnt == TO_LAST);
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = TIMEOUT_CYC;
  assign w_timeout   = 1'b0;
`endif

  assign w_finish = eng_done | w_timeout;
  // Read data is taken only on a real done; writes and aborts keep the original byte.
  assign w_data   = (r_rw && eng_done) ? eng_rdata : r_mdata;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      S_IDLE:  if (ena) w_next = S_SCAN;
      S_SCAN:  w_next = S_EVAL;
      S_EVAL: begin
        if (w_pending)  w_next = S_ISSUE;
        else if (ena)   w_next = S_SCAN;
        else            w_next = S_IDLE;
      end
      S_ISSUE: begin
        if (!eng_busy) begin
          w_start = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT:  if (w_finish) w_next = S_WB;
      S_WB:    w_next = ena ? S_SCAN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_maddr    <= '0;
      r_mdata    <= '0;
      r_wdata    <= '0;
      r_done_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_EVAL: begin
          r_rw    <= buf_rdata[29];
          r_maddr <= buf_rdata[6:0];
          r_mdata <= buf_rdata[14:7];
          if (!w_pending) r_addr <= r_addr + 1'b1;
        end
        S_WAIT: begin
          if (w_finish)
            r_wdata <= {1'b1, 1'b0, r_rw, 13'b0, w_timeout, w_data, r_maddr};
        end
        S_WB: begin
          r_addr     <= r_addr + 1'b1;
          r_done_cnt <= r_done_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign buf_addrb = r_addr;
  assign buf_wdata = r_wdata;
  assign web       = (r_state == S_WB);
  assign irq       = (r_state == S_WB);
  assign eng_start = w_start;
  assign eng_rw    = r_rw;
  assign eng_addr  = r_maddr;
  assign eng_wdata = r_mdata;
  assign done_cnt  = r_done_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_buf_sched.sv
// Directed bench for spi_buf_sched: behavioural port-B buffer, scripted engine, per-scenario checks.
module tb_spi_buf_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [7:0]  buf_addrb;
  logic [31:0] buf_rdata;
  logic [31:0] buf_wdata;
  logic        web, eng_start, eng_rw, irq;
  logic [6:0]  eng_addr;
  logic [7:0]  eng_wdata;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_rdata = 8'h00;
  logic [15:0] done_cnt;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:255];
  logic        pa_we = 1'b0;
  logic        pa_clr = 1'b0;
  logic [7:0]  pa_addr = 8'h00;
  logic [31:0] pa_data = 32'h0;
  int web_cnt = 0;
  int start_cnt = 0;
  int vecs = 0;
  int errs = 0;

  spi_buf_sched #(.DEPTH_LOG2(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .buf_addrb(buf_addrb), .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .web(web),
    .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .irq(irq), .done_cnt(done_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Port B: registered read, write on web; port A loads slots from the bench.
  always @(posedge clk) begin
    buf_rdata <= mem[buf_addrb];
    if (pa_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      if (web) mem[buf_addrb] <= buf_wdata;
      if (pa_we) mem[pa_addr] <= pa_data;
    end
    if (web) web_cnt <= web_cnt + 1;
    if (eng_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pa_write(input logic [7:0] a, input logic [31:0] d);
    pa_addr = a; pa_data = d; pa_we = 1'b1;
    tick(1);
    pa_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; eng_busy = 1'b0; eng_done = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (eng_start !== 1'b1 && cyc < 1200) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pa_clr = 1'b1;
    tick(2);
    pa_clr = 1'b0;
    tick(1);
    vecs++; if (buf_addrb !== 8'h00) begin $display("FAIL rst_addrb: got %h want 00", buf_addrb); errs++; end
    vecs++; if (dbg_state !== 3'd0) begin $display("FAIL rst_state: got %0d want 0", dbg_state); errs++; end
    vecs++; if ({web, eng_start, irq, eng_rw} !== 4'b0) begin $display("FAIL rst_strobes: got %b want 0000", {web, eng_start, irq, eng_rw}); errs++; end
    vecs++; if ({eng_addr, eng_wdata} !== 15'h0) begin $display("FAIL rst_eng_bus: got %h want 0", {eng_addr, eng_wdata}); errs++; end
    vecs++; if (buf_wdata !== 32'h0) begin $display("FAIL rst_wdata: got %h want 0", buf_wdata); errs++; end
    vecs++; if (done_cnt !== 16'h0) begin $display("FAIL rst_done_cnt: got %h want 0", done_cnt); errs++; end
    rst = 1'b0;
  endtask

  task automatic test_scan_idle();
    int w0;
    w0 = web_cnt;
    ena = 1'b1;
    tick(3);
    vecs++; if (buf_addrb !== 8'd1 || dbg_state !== 3'd1) begin $display("FAIL scan_step: got addr %0d state %0d want 1 1", buf_addrb, dbg_state); errs++; end
    tick(508);
    vecs++; if (buf_addrb !== 8'd255) begin $display("FAIL scan_255: got %0d want 255", buf_addrb); errs++; end
    tick(2);
    vecs++; if (buf_addrb !== 8'd0) begin $display("FAIL scan_wrap: got %0d want 0", buf_addrb); errs++; end
    ena = 1'b0;
    tick(4);
    vecs++; if (dbg_state !== 3'd0) begin $display("FAIL scan_park: got state %0d want 0", dbg_state); errs++; end
    vecs++; if (web_cnt - w0 !== 0) begin $display("FAIL scan_no_web: got %0d writes want 0", web_cnt - w0); errs++; end
  endtask

  task automatic test_write();
    int cyc, w0, s0;
    do_reset();
    pa_write(8'd5, 32'h4000_0123);
    w0 = web_cnt; s0 = start_cnt;
    ena = 1'b1;
    wait_start(cyc);
    vecs++; if (cyc !== 13) begin $display("FAIL wr_start_lat: got %0d cycles want 13", cyc); errs++; end
    vecs++; if ({eng_rw, eng_addr, eng_wdata} !== {1'b0, 7'h23, 8'h02}) begin $display("FAIL wr_eng_bus: got rw %b addr %h data %h want 0 23 02", eng_rw, eng_addr, eng_wdata); errs++; end
    tick(10);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    vecs++; if (web !== 1'b1 || irq !== 1'b1 || buf_addrb !== 8'd5) begin $display("FAIL wr_wb_strobe: got web %b irq %b addr %0d want 1 1 5", web, irq, buf_addrb); errs++; end
    vecs++; if (buf_wdata !== 32'h8000_0123) begin $display("FAIL wr_wb_data: got %h want 80000123", buf_wdata); errs++; end
    ena = 1'b0;
    tick(1);
    vecs++; if (done_cnt !== 16'd1 || web !== 1'b0) begin $display("FAIL wr_done_cnt: got cnt %0d web %b want 1 0", done_cnt, web); errs++; end
    vecs++; if (mem[5] !== 32'h8000_0123) begin $display("FAIL wr_slot5: got %h want 80000123", mem[5]); errs++; end
    tick(4);
    vecs++; if (web_cnt - w0 !== 1 || start_cnt - s0 !== 1) begin $display("FAIL wr_pulse_counts: got web %0d start %0d want 1 1", web_cnt - w0, start_cnt - s0); errs++; end
  endtask

  task automatic test_read();
    int cyc;
    do_reset();
    pa_write(8'd7, 32'h6000_0011);
    ena = 1'b1;
    wait_start(cyc);
    vecs++; if (eng_start !== 1'b1 || eng_rw !== 1'b1 || eng_addr !== 7'h11) begin $display("FAIL rd_issue: got start %b rw %b addr %h want 1 1 11", eng_start, eng_rw, eng_addr); errs++; end
    tick(3);
    eng_done = 1'b1; eng_rdata = 8'hA5;
    tick(1);
    eng_done = 1'b0; eng_rdata = 8'h00;
    vecs++; if (web !== 1'b1 || buf_wdata !== 32'hA000_5291) begin $display("FAIL rd_wb: got web %b data %h want 1 a0005291", web, buf_wdata); errs++; end
    ena = 1'b0;
    tick(1);
    vecs++; if (mem[7] !== 32'hA000_5291) begin $display("FAIL rd_slot7: got %h want a0005291", mem[7]); errs++; end
  endtask

  task automatic test_busy();
    int s0, w0;
    do_reset();
    pa_write(8'd3, 32'h4000_0042);
    s0 = start_cnt; w0 = web_cnt;
    eng_busy = 1'b1;
    ena = 1'b1;
    tick(15);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    tick(14);
    vecs++; if (dbg_state !== 3'd3) begin $display("FAIL busy_hold_state: got %0d want 3", dbg_state); errs++; end
    vecs++; if (start_cnt - s0 !== 0 || web_cnt - w0 !== 0) begin $display("FAIL busy_no_start: got start %0d web %0d want 0 0", start_cnt - s0, web_cnt - w0); errs++; end
    eng_busy = 1'b0;
    #1;
    vecs++; if (eng_start !== 1'b1) begin $display("FAIL busy_release_start: got %b want 1", eng_start); errs++; end
    tick(1);
    vecs++; if (eng_start !== 1'b0 || dbg_state !== 3'd4 || start_cnt - s0 !== 1) begin $display("FAIL busy_single_start: got start %b state %0d cnt %0d want 0 4 1", eng_start, dbg_state, start_cnt - s0); errs++; end
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    vecs++; if (web !== 1'b1 || buf_wdata !== 32'h8000_0042) begin $display("FAIL busy_wb: got web %b data %h want 1 80000042", web, buf_wdata); errs++; end
    ena = 1'b0;
    tick(2);
  endtask

  task automatic test_ena_drop();
    int cyc, w0;
    do_reset();
    pa_write(8'd4, 32'h6000_0033);
    w0 = web_cnt;
    ena = 1'b1;
    wait_start(cyc);
    tick(2);
    ena = 1'b0;
    tick(3);
    eng_done = 1'b1; eng_rdata = 8'h3C;
    tick(1);
    eng_done = 1'b0; eng_rdata = 8'h00;
    vecs++; if (web !== 1'b1 || buf_addrb !== 8'd4 || buf_wdata !== 32'hA000_1E33) begin $display("FAIL drop_wb: got web %b addr %0d data %h want 1 4 a0001e33", web, buf_addrb, buf_wdata); errs++; end
    tick(1);
    vecs++; if (dbg_state !== 3'd0 || buf_addrb !== 8'd5) begin $display("FAIL drop_idle: got state %0d addr %0d want 0 5", dbg_state, buf_addrb); errs++; end
    tick(5);
    vecs++; if (dbg_state !== 3'd0 || buf_addrb !== 8'd5 || web_cnt - w0 !== 1) begin $display("FAIL drop_hold: got state %0d addr %0d writes %0d want 0 5 1", dbg_state, buf_addrb, web_cnt - w0); errs++; end
  endtask

  task automatic test_timeout();
    int cyc, w0;
    do_reset();
    pa_write(8'd9, 32'h4000_0ABC);
    w0 = web_cnt;
    ena = 1'b1;
    wait_start(cyc);
    vecs++; if (eng_start !== 1'b1) begin $display("FAIL to_start_seen: got %b want 1", eng_start); errs++; end
`ifdef SPI_SCHED_TIMEOUT_EN
    cyc = 0;
    while (web !== 1'b1 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    vecs++; if (cyc !== 17) begin $display("FAIL to_latency: got %0d cycles want 17", cyc); errs++; end
    vecs++; if (buf_wdata !== 32'h8000_8ABC) begin $display("FAIL to_wb_data: got %h want 80008abc", buf_wdata); errs++; end
    ena = 1'b0;
    tick(1);
    vecs++; if (mem[9] !== 32'h8000_8ABC) begin $display("FAIL to_slot9: got %h want 80008abc", mem[9]); errs++; end
`else
    tick(1000);
    vecs++; if (web_cnt - w0 !== 0 || dbg_state !== 3'd4) begin $display("FAIL to_wait_forever: got writes %0d state %0d want 0 4", web_cnt - w0, dbg_state); errs++; end
    vecs++; if (mem[9] !== 32'h4000_0ABC) begin $display("FAIL to_slot9_kept: got %h want 40000abc", mem[9]); errs++; end
`endif
    do_reset();
    pa_write(8'd9, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    int cyc, w0;
    do_reset();
    pa_write(8'd2, 32'h6000_0155);
    w0 = web_cnt;
    ena = 1'b1;
    wait_start(cyc);
    tick(3);
    vecs++; if (dbg_state !== 3'd4) begin $display("FAIL rw_in_wait: got state %0d want 4", dbg_state); errs++; end
    rst = 1'b1;
    tick(1);
    vecs++; if (dbg_state !== 3'd0 || buf_addrb !== 8'd0 || done_cnt !== 16'd0) begin $display("FAIL rw_state: got state %0d addr %0d cnt %0d want 0 0 0", dbg_state, buf_addrb, done_cnt); errs++; end
    vecs++; if ({web, eng_start, irq, eng_rw, eng_addr, eng_wdata} !== 19'h0 || buf_wdata !== 32'h0) begin $display("FAIL rw_outputs: got %h %h want 0 0", {web, eng_start, irq, eng_rw, eng_addr, eng_wdata}, buf_wdata); errs++; end
    rst = 1'b0; ena = 1'b0;
    tick(3);
    vecs++; if (mem[2] !== 32'h6000_0155 || web_cnt - w0 !== 0) begin $display("FAIL rw_slot_kept: got %h writes %0d want 60000155 0", mem[2], web_cnt - w0); errs++; end
    pa_write(8'd2, 32'h0);
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_write();
    test_read();
    test_busy();
    test_ena_drop();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
